irq_priority_ctrl: RTL and testbench

Parametrised interrupt controller that generalises the single JK-style interrupt-enable flop into a multi-channel block. It provides per-channel rising-edge pending latches, per-channel masks, a fixed-priority encoder, and a global interrupt-enable (IEN) with JK set/clear/toggle semantics. A request/acknowledge/end-of-interrupt handshake connects it to the CPU core's interrupt entry logic.

---
 rtl/irq_priority_ctrl_if.sv | 27 ++
 rtl/irq_priority_ctrl.sv | 118 +++++++++++
 tb/tb_irq_priority_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_priority_ctrl_if.sv
// Signal bundle between the interrupt controller and the CPU interrupt-entry logic.
// The master side drives sources and handshake strobes; the slave side is the controller.
interface irq_priority_ctrl_if #(
   parameter int NUM_CH = 8,
   parameter int ID_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0] irq_in;
   logic [NUM_CH-1:0] mask;
   logic              ien_set;
   logic              ien_clr;
   logic              irq_ack;
   logic              eoi;
   logic              irq_req;
   logic [ID_W-1:0]   irq_id;
   logic              ien;
   logic [NUM_CH-1:0] pending;

   modport master (
      output irq_in, mask, ien_set, ien_clr, irq_ack, eoi,
      input  irq_req, irq_id, ien, pending
   );

   modport slave (
      input  irq_in, mask, ien_set, ien_clr, irq_ack, eoi,
      output irq_req, irq_id, ien, pending
   );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Multi-channel interrupt controller: edge-latched pending bits, masks, fixed priority
// (channel 0 highest), JK-style global enable and a req/ack/eoi handshake.
module irq_priority_ctrl #(
   parameter int NUM_CH = 8,
   parameter int ID_W   = $clog2(NUM_CH)
) (
   input  logic               clk,
   input  logic               rst_n,
   irq_priority_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] irq_in_q;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] clr_v;
   logic [NUM_CH-1:0] elig;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   winner;
   logic              ien_q, ien_d;
   logic              req_q;
   logic              ack_ok;

   // Lowest set index wins; scanning downward lets the last hit be the lowest one.
   function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   assign rise   = bus.irq_in & ~irq_in_q;
   assign elig   = pending_q & bus.mask;
   assign winner = lowest_set(elig);
   assign ack_ok = (state_q == REQ) && bus.irq_ack;

   // A fresh edge in the ack cycle outranks the clear, so the bit survives.
   always_comb begin
      clr_v = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clr_v[i] = ack_ok && (id_q == ID_W'(i));
      end
      pending_d = (pending_q & ~clr_v) | rise;
   end

   always_comb begin
      ien_d = ien_q;
      if (ack_ok) begin
         ien_d = 1'b0;
      end else begin
         case ({bus.ien_set, bus.ien_clr})
            2'b10:   ien_d = 1'b1;
            2'b01:   ien_d = 1'b0;
            2'b11:   ien_d = ~ien_q;
            default: ien_d = ien_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (ien_q && (elig != '0)) begin
               state_d = REQ;
               id_d    = winner;
            end
         end
         REQ: begin
            if (bus.irq_ack) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (bus.eoi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // irq_req gets its own flop so the CPU sees a clean registered level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         irq_in_q  <= '0;
         pending_q <= '0;
         ien_q     <= 1'b0;
         id_q      <= '0;
         req_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_in_q  <= bus.irq_in;
         pending_q <= pending_d;
         ien_q     <= ien_d;
         id_q      <= id_d;
         req_q     <= (state_d == REQ);
      end
   end

   assign bus.irq_req = req_q;
   assign bus.irq_id  = id_q;
   assign bus.ien     = ien_q;
   assign bus.pending = pending_q;

   a_req_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
      req_q == (state_q == REQ));

   a_id_frozen: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != IDLE) |=> $stable(id_q));

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed scenarios followed by random traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_irq_priority_ctrl;
   localparam int NUM_CH = 8;
   localparam int ID_W   = $clog2(NUM_CH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   irq_priority_ctrl_if #(.NUM_CH(NUM_CH), .ID_W(ID_W)) bus ();

   irq_priority_ctrl #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain bits and integers describing the controller's behaviour.
   bit m_prev[NUM_CH];
   bit m_pend[NUM_CH];
   bit m_ien;
   bit m_req;
   bit m_serv;
   int m_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_prev[i] = 1'b0;
         m_pend[i] = 1'b0;
      end
      m_ien  = 1'b0;
      m_req  = 1'b0;
      m_serv = 1'b0;
      m_id   = 0;
   endtask

   task automatic drv(input logic [7:0] in_v, input logic [7:0] msk, input bit s,
                      input bit c, input bit a, input bit e);
      bus.irq_in  = in_v;
      bus.mask    = msk;
      bus.ien_set = s;
      bus.ien_clr = c;
      bus.irq_ack = a;
      bus.eoi     = e;
   endtask

   // Advance one clock: compute what the model expects, take the edge, compare.
   task automatic tick();
      bit                ack_t;
      bit                np[NUM_CH];
      bit                nien, nreq, nserv;
      int                nid, win;
      logic [NUM_CH-1:0] pv;
      ack_t = m_req && bus.irq_ack;
      for (int i = 0; i < NUM_CH; i++) begin
         np[i] = (bus.irq_in[i] && !m_prev[i]) || (m_pend[i] && !(ack_t && m_id == i));
      end
      if (ack_t)                          nien = 1'b0;
      else if (bus.ien_set && !bus.ien_clr) nien = 1'b1;
      else if (!bus.ien_set && bus.ien_clr) nien = 1'b0;
      else if (bus.ien_set && bus.ien_clr)  nien = !m_ien;
      else                                nien = m_ien;
      nreq  = m_req;
      nserv = m_serv;
      nid   = m_id;
      if (!m_req && !m_serv) begin
         win = -1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (win < 0 && m_pend[i] && bus.mask[i]) win = i;
         end
         if (m_ien && win >= 0) begin
            nreq = 1'b1;
            nid  = win;
         end
      end else if (m_req) begin
         if (bus.irq_ack) begin
            nreq  = 1'b0;
            nserv = 1'b1;
         end
      end else if (bus.eoi) begin
         nserv = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         m_prev[i] = bus.irq_in[i];
         m_pend[i] = np[i];
      end
      m_ien  = nien;
      m_req  = nreq;
      m_serv = nserv;
      m_id   = nid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) pv[i] = m_pend[i];
      chk("irq_req", 32'(bus.irq_req), 32'(m_req));
      chk("irq_id", 32'(bus.irq_id), 32'(m_id));
      chk("ien", 32'(bus.ien), 32'(m_ien));
      chk("pending", 32'(bus.pending), 32'(pv));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, 32'(bus.irq_req), 32'd0);
      chk({tag, "_id"}, 32'(bus.irq_id), 32'd0);
      chk({tag, "_ien"}, 32'(bus.ien), 32'd0);
      chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
   endtask

   // Drop reset between edges, check outputs clear at once, release just after an edge.
   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      drv(8'h01, 8'hFF, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_hold");

      // Input already high at reset release counts as an edge
      rst_n = 1'b1;
      drv(8'h01, 8'hFF, 1, 0, 0, 0); tick();
      chk("basic_pending", 32'(bus.pending), 32'h01);
      drv(8'h01, 8'hFF, 0, 0, 0, 0); tick();
      chk("basic_req", 32'(bus.irq_req), 32'd1);
      chk("basic_id", 32'(bus.irq_id), 32'd0);
      drv(8'h01, 8'hFF, 0, 0, 1, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();

      // Priority with channel 3 masked, then unmasked
      drv(8'h28, 8'hF7, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hF7, 0, 0, 0, 0); tick();
      chk("prio_masked_id", 32'(bus.irq_id), 32'd5);
      chk("prio_masked_req", 32'(bus.irq_req), 32'd1);
      drv(8'h00, 8'hF7, 0, 0, 1, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();
      drv(8'h00, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      chk("prio_unmasked_id", 32'(bus.irq_id), 32'd3);

      // Ack together with ien_set: ack wins
      drv(8'h00, 8'hFF, 1, 0, 1, 0); tick();
      chk("ack_ien", 32'(bus.ien), 32'd0);
      chk("ack_pending", 32'(bus.pending), 32'h00);
      chk("ack_req", 32'(bus.irq_req), 32'd0);
      drv(8'h02, 8'hFF, 0, 0, 1, 0); tick();
      chk("stray_ack_ien", 32'(bus.ien), 32'd0);
      chk("stray_ack_pending", 32'(bus.pending), 32'h02);
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      tick();
      chk("no_req_ien0", 32'(bus.irq_req), 32'd0);
      drv(8'h00, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      chk("ch1_id", 32'(bus.irq_id), 32'd1);
      drv(8'h00, 8'hFF, 0, 0, 1, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();

      // JK enable sequence from ien=0
      drv(8'h00, 8'hFF, 1, 0, 0, 0); tick(); chk("jk_10", 32'(bus.ien), 32'd1);
      drv(8'h00, 8'hFF, 0, 1, 0, 0); tick(); chk("jk_01", 32'(bus.ien), 32'd0);
      drv(8'h00, 8'hFF, 1, 1, 0, 0); tick(); chk("jk_11a", 32'(bus.ien), 32'd1);
      drv(8'h00, 8'hFF, 1, 1, 0, 0); tick(); chk("jk_11b", 32'(bus.ien), 32'd0);
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick(); chk("jk_00", 32'(bus.ien), 32'd0);

      // New edge on the channel being acked keeps its pending bit
      drv(8'h04, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      drv(8'h04, 8'hFF, 0, 0, 1, 0); tick();
      chk("edge_on_ack_pending", 32'(bus.pending), 32'h04);
      chk("edge_on_ack_req", 32'(bus.irq_req), 32'd0);
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();
      drv(8'h00, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      chk("rereq_req", 32'(bus.irq_req), 32'd1);
      chk("rereq_id", 32'(bus.irq_id), 32'd2);
      drv(8'h00, 8'hFF, 0, 0, 1, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 1); tick();

      // Async reset while ACTIVE, with a source held high across it
      drv(8'h10, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 0, 0); tick();
      drv(8'h00, 8'hFF, 0, 0, 1, 0); tick();
      drv(8'h01, 8'hFF, 1, 0, 0, 0); tick();
      drv(8'h01, 8'hFF, 0, 0, 0, 0);
      async_reset();
      tick();
      chk("post_rst_pending", 32'(bus.pending), 32'h01);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         drv(8'($urandom) & 8'($urandom), 8'($urandom) | 8'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
         tick();
         if (n == 400) async_reset();
      end

      drv(8'h00, 8'hFF, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
